// File: rtl/serial_pkg.sv
// Shared definitions for the serial datapath: serializer, shift register and deserializer.
package serial_pkg;

    // Serializer control states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } serial_state_t;

    // Default word shape shared by every block on the serial link.
    localparam int DEFAULT_WIDTH     = 32'sd4;
    localparam int DEFAULT_IDLE_BITS = 32'sd0;
    localparam bit DEFAULT_MSB_FIRST = 1'b1;

    // Width needed to hold the values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        int w;
        if (n <= 32'sd2) begin
            w = 32'sd1;
        end else begin
            w = $clog2(n);
        end
        return w;
    endfunction

endpackage

// File: rtl/frame_counter.sv
// Loadable down-counter with a terminal-count flag; serves as bit and gap counter.
module frame_counter #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          tc
);

    // Terminal count: the counter has reached zero.
    assign tc = (count == {CW{1'b0}});

    // Load takes priority over decrement; the counter parks at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= {CW{1'b0}};
        end else if (load) begin
            count <= load_value;
        end else if (dec && !tc) begin
            count <= count - CW'(1'b1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with optional zero gap between words and frame flags.
module piso_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int IDLE_BITS = DEFAULT_IDLE_BITS,
    parameter bit MSB_FIRST = DEFAULT_MSB_FIRST
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             LOAD_VALID,
    output logic             LOAD_READY,
    output logic             DOUT,
    output logic             FRAME,
    output logic             DONE,
    output logic             BUSY
);

    localparam int BW = cnt_width(WIDTH);
    localparam int GW = cnt_width(IDLE_BITS + 32'sd1);
    localparam bit HAS_GAP = (IDLE_BITS > 32'sd0);
    localparam bit GAP_ONE = (IDLE_BITS == 32'sd1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 32'sd1);
    localparam logic [BW-1:0] BIT_PENULT = BW'(32'sd1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(HAS_GAP ? (IDLE_BITS - 32'sd1) : 32'sd0);
    localparam logic [GW-1:0] GAP_PENULT = GW'(32'sd1);

    serial_state_t    state_r, state_s;
    logic [WIDTH-1:0] shreg_r, shreg_s;
    logic             dout_r, dout_s;
    logic             frame_r, frame_s;
    logic             done_r, done_s;
    logic             busy_r, busy_s;
    logic             ready_r, ready_s;

    logic             accept_s;
    logic             bit_dec_s;
    logic             gap_load_s;
    logic             gap_dec_s;
    logic [BW-1:0]    bit_count_s;
    logic             bit_tc_s;
    logic [GW-1:0]    gap_count_s;
    logic             gap_tc_s;

    // Bit that leaves the word first for the configured bit order.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        logic b;
        if (MSB_FIRST) begin
            b = w[WIDTH-1];
        end else begin
            b = w[0];
        end
        return b;
    endfunction

    // Word with its first bit consumed, so the next one moves to the head.
    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] s;
        if (MSB_FIRST) begin
            s = {w[WIDTH-2:0], 1'b0};
        end else begin
            s = {1'b0, w[WIDTH-1:1]};
        end
        return s;
    endfunction

    // Ready is only ever high in a cycle where a new word may start, so an accept always starts one.
    assign accept_s = LOAD_VALID & ready_r;

    // Counts the data bits still to come after the one currently on DOUT.
    frame_counter #(.CW(BW)) u_bit_cnt (
        .clk        (CLK),
        .rst_n      (RST),
        .load       (accept_s),
        .load_value (BIT_LAST),
        .dec        (bit_dec_s),
        .count      (bit_count_s),
        .tc         (bit_tc_s)
    );

    // Counts the gap cycles still to come after the current one.
    frame_counter #(.CW(GW)) u_gap_cnt (
        .clk        (CLK),
        .rst_n      (RST),
        .load       (gap_load_s),
        .load_value (GAP_LAST),
        .dec        (gap_dec_s),
        .count      (gap_count_s),
        .tc         (gap_tc_s)
    );

    // Next state and next registered outputs; outputs describe the cycle after the edge.
    always_comb begin
        state_s    = state_r;
        shreg_s    = shreg_r;
        dout_s     = 1'b0;
        frame_s    = 1'b0;
        done_s     = 1'b0;
        busy_s     = 1'b0;
        ready_s    = 1'b0;
        bit_dec_s  = 1'b0;
        gap_load_s = 1'b0;
        gap_dec_s  = 1'b0;
        if (accept_s) begin
            state_s = S_SHIFT;
            shreg_s = shift_word(DATA_IN);
            dout_s  = head_bit(DATA_IN);
            frame_s = 1'b1;
            busy_s  = 1'b1;
        end else begin
            case (state_r)
                S_IDLE: begin
                    ready_s = 1'b1;
                end
                S_SHIFT: begin
                    if (!bit_tc_s) begin
                        dout_s    = head_bit(shreg_r);
                        shreg_s   = shift_word(shreg_r);
                        frame_s   = 1'b1;
                        busy_s    = 1'b1;
                        bit_dec_s = 1'b1;
                        done_s    = (bit_count_s == BIT_PENULT);
                        ready_s   = (bit_count_s == BIT_PENULT) && !HAS_GAP;
                    end else if (HAS_GAP) begin
                        state_s    = S_GAP;
                        gap_load_s = 1'b1;
                        busy_s     = 1'b1;
                        ready_s    = GAP_ONE;
                    end else begin
                        state_s = S_IDLE;
                        ready_s = 1'b1;
                    end
                end
                S_GAP: begin
                    if (!gap_tc_s) begin
                        gap_dec_s = 1'b1;
                        busy_s    = 1'b1;
                        ready_s   = (gap_count_s == GAP_PENULT);
                    end else begin
                        state_s = S_IDLE;
                        ready_s = 1'b1;
                    end
                end
                default: begin
                    state_s = S_IDLE;
                    ready_s = 1'b0;
                end
            endcase
        end
    end

    // State, shift register and output registers; reset aborts any frame immediately.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= S_IDLE;
            shreg_r <= {WIDTH{1'b0}};
            dout_r  <= 1'b0;
            frame_r <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_s;
            shreg_r <= shreg_s;
            dout_r  <= dout_s;
            frame_r <= frame_s;
            done_r  <= done_s;
            busy_r  <= busy_s;
            ready_r <= ready_s;
        end
    end

    assign DOUT       = dout_r;
    assign FRAME      = frame_r;
    assign DONE       = done_r;
    assign BUSY       = busy_r;
    assign LOAD_READY = ready_r;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: four serializer configurations against a frame-position model.
module tb_piso_serializer;

    localparam int NI = 4;

    logic       clk;
    logic       rst;
    logic       valid [NI];
    logic [7:0] data  [NI];
    logic       dout  [NI];
    logic       frame [NI];
    logic       done  [NI];
    logic       busy  [NI];
    logic       ready [NI];

    int checks = 0;
    int errors = 0;

    // Model: a word is a frame of W data positions followed by IB gap positions.
    bit         m_active [NI];
    int         m_p      [NI];
    logic [7:0] m_word   [NI];
    bit         m_acc    [NI];
    logic       exp_dout [NI];
    logic       exp_frame[NI];
    logic       exp_done [NI];
    logic       exp_busy [NI];
    logic       exp_ready[NI];
    bit         n_acc    [NI];
    bit         n_act    [NI];
    int         n_p      [NI];
    logic [7:0] n_w      [NI];

    function automatic int p_w(input int i);
        return (i == 3) ? 5 : 4;
    endfunction
    function automatic int p_ib(input int i);
        return (i == 1) ? 2 : ((i == 3) ? 3 : 0);
    endfunction
    function automatic bit p_msb(input int i);
        return (i < 2);
    endfunction
    function automatic logic bit_of(input logic [7:0] w, input int i, input int p);
        int idx;
        if (p < 0 || p >= p_w(i)) return 1'b0;
        idx = p_msb(i) ? (p_w(i) - 1 - p) : p;
        return w[idx];
    endfunction

    piso_serializer #(.WIDTH(4), .IDLE_BITS(0), .MSB_FIRST(1'b1)) u0 (
        .CLK(clk), .RST(rst), .DATA_IN(data[0][3:0]), .LOAD_VALID(valid[0]),
        .LOAD_READY(ready[0]), .DOUT(dout[0]), .FRAME(frame[0]), .DONE(done[0]), .BUSY(busy[0]));
    piso_serializer #(.WIDTH(4), .IDLE_BITS(2), .MSB_FIRST(1'b1)) u1 (
        .CLK(clk), .RST(rst), .DATA_IN(data[1][3:0]), .LOAD_VALID(valid[1]),
        .LOAD_READY(ready[1]), .DOUT(dout[1]), .FRAME(frame[1]), .DONE(done[1]), .BUSY(busy[1]));
    piso_serializer #(.WIDTH(4), .IDLE_BITS(0), .MSB_FIRST(1'b0)) u2 (
        .CLK(clk), .RST(rst), .DATA_IN(data[2][3:0]), .LOAD_VALID(valid[2]),
        .LOAD_READY(ready[2]), .DOUT(dout[2]), .FRAME(frame[2]), .DONE(done[2]), .BUSY(busy[2]));
    piso_serializer #(.WIDTH(5), .IDLE_BITS(3), .MSB_FIRST(1'b0)) u3 (
        .CLK(clk), .RST(rst), .DATA_IN(data[3][4:0]), .LOAD_VALID(valid[3]),
        .LOAD_READY(ready[3]), .DOUT(dout[3]), .FRAME(frame[3]), .DONE(done[3]), .BUSY(busy[3]));

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model next position from the accept rule and the frame length.
    always_comb begin
        for (int i = 0; i < NI; i++) begin
            n_acc[i] = valid[i] && exp_ready[i];
            n_act[i] = n_acc[i] || (m_active[i] && (m_p[i] + 1 < p_w(i) + p_ib(i)));
            n_p[i]   = n_acc[i] ? 0 : (n_act[i] ? m_p[i] + 1 : 0);
            n_w[i]   = n_acc[i] ? data[i] : m_word[i];
        end
    end

    // Model registers: expected outputs follow from the frame position.
    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst) begin
                m_active[i] <= 1'b0; m_p[i] <= 0; m_acc[i] <= 1'b0; m_word[i] <= 8'h00;
                exp_dout[i] <= 1'b0; exp_frame[i] <= 1'b0; exp_done[i] <= 1'b0;
                exp_busy[i] <= 1'b0; exp_ready[i] <= 1'b0;
            end else begin
                m_active[i]  <= n_act[i];
                m_p[i]       <= n_p[i];
                m_word[i]    <= n_w[i];
                m_acc[i]     <= n_acc[i];
                exp_frame[i] <= n_act[i] && (n_p[i] < p_w(i));
                exp_dout[i]  <= n_act[i] && bit_of(n_w[i], i, n_p[i]);
                exp_done[i]  <= n_act[i] && (n_p[i] == p_w(i) - 1);
                exp_busy[i]  <= n_act[i];
                exp_ready[i] <= !n_act[i] || (n_p[i] == p_w(i) + p_ib(i) - 1);
            end
        end
    end

    // Cycle-by-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            check($sformatf("u%0d.DOUT", i),       32'(dout[i]),  32'(exp_dout[i]));
            check($sformatf("u%0d.FRAME", i),      32'(frame[i]), 32'(exp_frame[i]));
            check($sformatf("u%0d.DONE", i),       32'(done[i]),  32'(exp_done[i]));
            check($sformatf("u%0d.BUSY", i),       32'(busy[i]),  32'(exp_busy[i]));
            check($sformatf("u%0d.LOAD_READY", i), 32'(ready[i]), 32'(exp_ready[i]));
        end
    end

    // Shift n negedge samples of one instance into vectors, oldest sample in the MSB.
    task automatic collect(input int i, input int n, output logic [15:0] b,
                           output logic [15:0] f, output logic [15:0] d, output logic [15:0] r);
        b = 16'h0; f = 16'h0; d = 16'h0; r = 16'h0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            b = {b[14:0], dout[i]};
            f = {f[14:0], frame[i]};
            d = {d[14:0], done[i]};
            r = {r[14:0], ready[i]};
        end
    endtask

    logic [15:0] cb, cf, cd, cr;

    // Single 4'b1001 word on u0, then back to idle.
    task automatic test_single(input string nm);
        @(posedge clk); #2;
        valid[0] = 1'b1; data[0] = 8'h09;
        @(posedge clk); #2;
        valid[0] = 1'b0;
        collect(0, 5, cb, cf, cd, cr);
        check({nm, ".bits"},  32'(cb), 32'h12);
        check({nm, ".frame"}, 32'(cf), 32'h1E);
        check({nm, ".done"},  32'(cd), 32'h02);
        check({nm, ".ready"}, 32'(cr), 32'h03);
    endtask

    // Two words with valid held: 1001 then 1011 on instance i.
    task automatic test_pair(input int i, input string nm);
        @(posedge clk); #2;
        valid[i] = 1'b1; data[i] = 8'h09;
        @(posedge clk); #2;
        data[i] = 8'h0B;
        fork
            collect(i, 9, cb, cf, cd, cr);
            begin
                repeat (4) @(posedge clk);
                #2 valid[i] = 1'b0;
            end
        join
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            valid[i] = 1'b0;
            data[i]  = 8'h00;
        end
        #1 rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("reset.outputs", 32'({dout[0], frame[0], done[0], busy[0], ready[0]}), 32'h0);
        end
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        check("release.ready_before_edge", 32'(ready[0]), 32'h0);
        @(negedge clk);
        check("release.ready_after_edge", 32'(ready[0]), 32'h1);
        check("release.dout_idle", 32'(dout[0]), 32'h0);

        test_single("single");

        test_pair(0, "b2b");
        check("b2b.bits",  32'(cb), 32'h136);
        check("b2b.frame", 32'(cf), 32'h1FE);
        check("b2b.done",  32'(cd), 32'h022);
        check("b2b.ready", 32'(cr), 32'h023);

        // Gap of two between 1011 and 1001 on u1.
        @(posedge clk); #2;
        valid[1] = 1'b1; data[1] = 8'h0B;
        @(posedge clk); #2;
        data[1] = 8'h09;
        fork
            collect(1, 12, cb, cf, cd, cr);
            begin
                repeat (6) @(posedge clk);
                #2 valid[1] = 1'b0;
            end
        join
        check("gap.bits",  32'(cb), 32'hB24);
        check("gap.frame", 32'(cf), 32'hF3C);
        check("gap.done",  32'(cd), 32'h104);
        check("gap.ready", 32'(cr), 32'h041);

        test_pair(2, "lsb");
        check("lsb.bits",  32'(cb), 32'h13A);
        check("lsb.frame", 32'(cf), 32'h1FE);

        // Reset during the third bit of 1011 on u0.
        @(posedge clk); #2;
        valid[0] = 1'b1; data[0] = 8'h0B;
        @(posedge clk); #2;
        valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("abort.dout_before", 32'({dout[0], frame[0], busy[0]}), 32'h7);
        rst = 1'b0;
        #1;
        check("abort.outputs", 32'({dout[0], frame[0], busy[0], done[0], ready[0]}), 32'h0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        test_single("after_abort");

        // Randomized traffic on all instances, with one reset in the middle.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            if (c == 1500) rst = 1'b0;
            if (c == 1502) rst = 1'b1;
            for (int i = 0; i < NI; i++) begin
                if (!valid[i] || m_acc[i]) begin
                    valid[i] = ($urandom_range(0, 3) != 0);
                    data[i]  = 8'($urandom);
                end
            end
        end
        for (int i = 0; i < NI; i++) valid[i] = 1'b0;
        repeat (12) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
